vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 183 ++++++++++++++++++
 tb/tb_vga_timing.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Free-running raster timing generator for the VDP. It drives the tile
// renderer's raster inputs once per pixel clock: the pixel position, the sync
// pulses, the visible-area flag and a border flag. The border flag marks
// visible pixels outside the WIN_COLS x WIN_ROWS pattern window, which is
// anchored at column 0 / row 0 of the visible area.
//
// The defaults give standard 640x480@60 timing (800 x 525 totals).
// H_TOTAL and V_TOTAL must both be <= 1024 because the counters are 10 bits.
//
// Optional feature (compile-time macro VGA_TIMING_VBLANK_IRQ_EN):
//   Adds a vertical-blank interrupt. The IRQ is set when the raster reaches
//   the first pixel of the first blank line (h==0, v==V_ACTIVE). It is held
//   until vblank_ack is sampled high. Set wins over a simultaneous ack.
//   Without the macro, neither IRQ port nor the IRQ flop exists.
//
// Ports:
//   pxclk        in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   col_out      out  [9:0] horizontal position, 0..H_TOTAL-1
//   row_out      out  [9:0] vertical position, 0..V_TOTAL-1
//   hsync_out    out  horizontal sync, active low
//   vsync_out    out  vertical sync, active low
//   active_out   out  visible pixel
//   border_out   out  visible pixel outside the pattern window
//   line_start   out  one-cycle pulse when col_out==0
//   frame_start  out  one-cycle pulse when col_out==0 and row_out==0
//   vblank_irq   out  vertical-blank interrupt (macro builds only)
//   vblank_ack   in   interrupt acknowledge (macro builds only)
//
// Every output is a flop fed from the current counter values, so the outputs
// show the counter state of the previous cycle. Position and flags for one
// counter state always appear on the same edge.
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_COLS = 512,
    parameter int WIN_ROWS = 384
) (
    input  logic       pxclk,
    input  logic       reset_n,
    output logic [9:0] col_out,
    output logic [9:0] row_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       active_out,
    output logic       border_out,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    ,
    output logic       vblank_irq,
    input  logic       vblank_ack
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit decode constants.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WIN_C      = 10'(WIN_COLS);
    localparam logic [9:0] WIN_R      = 10'(WIN_ROWS);

    // Raster counters.
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Registered outputs.
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       active_q, active_d;
    logic       border_q, border_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    logic       h_last;
    logic       v_last;

    always_comb begin
        h_last = (h_cnt_q == H_LAST);
        v_last = (v_cnt_q == V_LAST);

        // Horizontal counter wraps every H_TOTAL cycles; vertical counter
        // steps only on the horizontal wrap.
        h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
        end

        // Decode of the current counter state; registered below so all
        // outputs for one raster position leave together.
        col_d         = h_cnt_q;
        row_d         = v_cnt_q;
        active_d      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        border_d      = active_d && ((h_cnt_q >= WIN_C) || (v_cnt_q >= WIN_R));
        hsync_d       = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
        // v_cnt only changes at h==0, so vsync edges line up with line starts.
        vsync_d       = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
        line_start_d  = (h_cnt_q == 10'd0);
        frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            border_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            border_q      <= border_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign col_out     = col_q;
    assign row_out     = row_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign active_out  = active_q;
    assign border_out  = border_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_VBLANK_IRQ_EN
    logic irq_q, irq_d;

    // Set is decoded from the counters, so the IRQ rises on the same edge
    // that row_out becomes V_ACTIVE with col_out 0. Set has priority over ack.
    always_comb begin
        irq_d = irq_q;
        if ((h_cnt_q == 10'd0) && (v_cnt_q == V_ACT_END)) begin
            irq_d = 1'b1;
        end else if (vblank_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign vblank_irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Two instances share clock and reset: "dut" uses a shrunken raster
// (58 x 40 totals, 32 x 24 window) so whole frames fit in a short run, and
// "dut_d" uses the default 640x480 parameters for line-level checks.
// A reference model derives the expected outputs from the number of clock
// edges since reset release with plain division/modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    // Small raster parameters.
    localparam int S_HA = 40, S_HFP = 4, S_HS = 8, S_HBP = 6;
    localparam int S_VA = 30, S_VFP = 2, S_VS = 3, S_VBP = 5;
    localparam int S_WC = 32, S_WR = 24;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;  // 58
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;  // 40

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       act;
        logic       bord;
        logic       ls;
        logic       fs;
    } vec_t;

    typedef struct {
        int   h;
        int   v;
        logic act;
        logic bord;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } tv_t;

    logic pxclk;
    logic reset_n;

    logic [9:0] s_col, s_row, d_col, d_row;
    logic s_hs, s_vs, s_act, s_bord, s_ls, s_fs;
    logic d_hs, d_vs, d_act, d_bord, d_ls, d_fs;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    logic s_irq, d_irq;
    logic vblank_ack;
    logic ack_zero;
    logic irq_m;
`endif

    int n_chk;
    int n_pass;
    int k;  // edges since reset release

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .WIN_COLS(S_WC), .WIN_ROWS(S_WR)
    ) dut (
        .pxclk      (pxclk),
        .reset_n    (reset_n),
        .col_out    (s_col),
        .row_out    (s_row),
        .hsync_out  (s_hs),
        .vsync_out  (s_vs),
        .active_out (s_act),
        .border_out (s_bord),
        .line_start (s_ls),
        .frame_start(s_fs)
`ifdef VGA_TIMING_VBLANK_IRQ_EN
        ,
        .vblank_irq (s_irq),
        .vblank_ack (vblank_ack)
`endif
    );

    vga_timing dut_d (
        .pxclk      (pxclk),
        .reset_n    (reset_n),
        .col_out    (d_col),
        .row_out    (d_row),
        .hsync_out  (d_hs),
        .vsync_out  (d_vs),
        .active_out (d_act),
        .border_out (d_bord),
        .line_start (d_ls),
        .frame_start(d_fs)
`ifdef VGA_TIMING_VBLANK_IRQ_EN
        ,
        .vblank_irq (d_irq),
        .vblank_ack (ack_zero)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        pxclk = 1'b0;
        forever #5 pxclk = ~pxclk;
    end

    // ---------------- reference model ----------------
    function automatic vec_t model(input int kk, input int ha, input int hfp,
                                   input int hs, input int hbp, input int va,
                                   input int vfp, input int vs, input int vbp,
                                   input int wc, input int wr);
        vec_t r;
        int ht, vt, pos, h, v;
        r.col  = 10'd0;
        r.row  = 10'd0;
        r.hs   = 1'b1;
        r.vs   = 1'b1;
        r.act  = 1'b0;
        r.bord = 1'b0;
        r.ls   = 1'b0;
        r.fs   = 1'b0;
        if (kk > 0) begin
            ht  = ha + hfp + hs + hbp;
            vt  = va + vfp + vs + vbp;
            pos = (kk - 1) % (ht * vt);
            h   = pos % ht;
            v   = pos / ht;
            r.col  = 10'(h);
            r.row  = 10'(v);
            r.act  = (h < ha) && (v < va);
            r.bord = r.act && ((h >= wc) || (v >= wr));
            r.hs   = !((h >= ha + hfp) && (h < ha + hfp + hs));
            r.vs   = !((v >= va + vfp) && (v < va + vfp + vs));
            r.ls   = (h == 0);
            r.fs   = (h == 0) && (v == 0);
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic vec_t pack_s();
        vec_t r;
        r.col = s_col; r.row = s_row; r.hs = s_hs; r.vs = s_vs;
        r.act = s_act; r.bord = s_bord; r.ls = s_ls; r.fs = s_fs;
        return r;
    endfunction

    function automatic vec_t pack_d();
        vec_t r;
        r.col = d_col; r.row = d_row; r.hs = d_hs; r.vs = d_vs;
        r.act = d_act; r.bord = d_bord; r.ls = d_ls; r.fs = d_fs;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: wait for the edge, sample 1 time unit later, compare both
    // instances (and the IRQ) with the model.
    task automatic tick();
        vec_t es, ed;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
        logic ack_s;
        ack_s = vblank_ack;
`endif
        @(posedge pxclk);
        #1;
        if (reset_n) k++;
        es = model(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_WC, S_WR);
        ed = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 512, 384);
        chk("small_raster", 32'(pack_s()), 32'(es));
        chk("dflt_raster", 32'(pack_d()), 32'(ed));
`ifdef VGA_TIMING_VBLANK_IRQ_EN
        if (!reset_n) begin
            irq_m = 1'b0;
        end else if ((k - 1) % (S_HT * S_VT) == S_VA * S_HT) begin
            irq_m = 1'b1;
        end else if (ack_s) begin
            irq_m = 1'b0;
        end
        chk("small_irq", 32'(s_irq), 32'(irq_m));
        chk("dflt_irq", 32'(d_irq), 32'd0);
`endif
    endtask

    // Assert reset asynchronously mid-cycle, check outputs at once, then
    // release just after a rising edge.
    task automatic do_reset();
        vec_t rv;
        @(negedge pxclk);
        #1;
        reset_n = 1'b0;
        #1;
        rv = model(0, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_WC, S_WR);
        chk("async_reset_small", 32'(pack_s()), 32'(rv));
        chk("async_reset_dflt", 32'(pack_d()), 32'(rv));
`ifdef VGA_TIMING_VBLANK_IRQ_EN
        chk("async_reset_irq", 32'(s_irq), 32'd0);
        irq_m = 1'b0;
`endif
        k = 0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!((32'(s_col) == h) && (32'(s_row) == v)) && n < 4000);
        chk($sformatf("reach_%0d_%0d", h, v),
            32'((32'(s_col) == h) && (32'(s_row) == v)), 32'd1);
    endtask

    // ---------------- test ----------------
    tv_t tbl[19];

    initial begin
        int cnt_a, cnt_b, cnt_v, cnt_f, cnt_h, cnt_l, first_h, t_fs;
        n_chk   = 0;
        n_pass  = 0;
        k       = 0;
        reset_n = 1'b0;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
        vblank_ack = 1'b0;
        ack_zero   = 1'b0;
        irq_m      = 1'b0;
`endif

        //          h   v  act brd hs vs ls fs
        tbl = '{
            '{ 0,  0, 1, 0, 1, 1, 1, 1},
            '{ 1,  0, 1, 0, 1, 1, 0, 0},
            '{31, 10, 1, 0, 1, 1, 0, 0},
            '{32, 10, 1, 1, 1, 1, 0, 0},
            '{39, 10, 1, 1, 1, 1, 0, 0},
            '{40, 10, 0, 0, 1, 1, 0, 0},
            '{43, 10, 0, 0, 1, 1, 0, 0},
            '{44, 10, 0, 0, 0, 1, 0, 0},
            '{51, 10, 0, 0, 0, 1, 0, 0},
            '{52, 10, 0, 0, 1, 1, 0, 0},
            '{31, 23, 1, 0, 1, 1, 0, 0},
            '{ 0, 24, 1, 1, 1, 1, 1, 0},
            '{57, 29, 0, 0, 1, 1, 0, 0},
            '{ 0, 30, 0, 0, 1, 1, 1, 0},
            '{ 0, 32, 0, 0, 1, 0, 1, 0},
            '{50, 34, 0, 0, 0, 0, 0, 0},
            '{ 0, 35, 0, 0, 1, 1, 1, 0},
            '{57, 39, 0, 0, 1, 1, 0, 0},
            '{ 0,  0, 1, 0, 1, 1, 1, 1}
        };

        // Table-driven decode checks across one small frame and its wrap.
        do_reset();
        foreach (tbl[i]) begin
            wait_pos(tbl[i].h, tbl[i].v);
            chk($sformatf("tbl%0d_flags", i),
                32'({s_act, s_bord, s_hs, s_vs, s_ls, s_fs}),
                32'({tbl[i].act, tbl[i].bord, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs}));
        end

        // Mid-frame reset, then the first edge after release.
        wait_pos(30, 20);
        do_reset();
        tick();
        chk("post_release", 32'({s_col, s_row, s_act, s_fs, s_ls}),
            32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));

        // Default raster: one full line of hsync / line_start.
        do_reset();
        cnt_h = 0; cnt_l = 0; first_h = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!d_hs) begin
                if (first_h < 0) first_h = 32'(d_col);
                cnt_h++;
            end
            if (d_ls) cnt_l++;
        end
        chk("dflt_hsync_low_cycles", 32'(cnt_h), 32'd96);
        chk("dflt_hsync_first_col", 32'(first_h), 32'd656);
        chk("dflt_line_start_per_line", 32'(cnt_l), 32'd1);
        tick();
        chk("dflt_line_period", 32'({d_ls, d_col}), 32'({1'b1, 10'd0}));

        // Small raster: one full frame of counts, then the frame period.
        do_reset();
        cnt_a = 0; cnt_b = 0; cnt_v = 0; cnt_f = 0;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            tick();
            if (s_act) cnt_a++;
            if (s_bord) cnt_b++;
            if (!s_vs) cnt_v++;
            if (s_fs) cnt_f++;
        end
        chk("frame_active_cycles", 32'(cnt_a), 32'(S_HA * S_VA));
        chk("frame_border_cycles", 32'(cnt_b), 32'(S_HA * S_VA - S_WC * S_WR));
        chk("frame_vsync_low_cycles", 32'(cnt_v), 32'(S_VS * S_HT));
        chk("frame_start_count", 32'(cnt_f), 32'd1);
        t_fs = 0;
        do begin
            tick();
            t_fs++;
        end while (!s_fs && t_fs < 4000);
        chk("frame_period", 32'(k - 1), 32'(S_HT * S_VT));

`ifdef VGA_TIMING_VBLANK_IRQ_EN
        // IRQ rises with row V_ACTIVE / col 0, holds, clears on one ack.
        do_reset();
        wait_pos(0, S_VA);
        chk("irq_rise", 32'(s_irq), 32'd1);
        cnt_h = 0;
        for (int i = 0; i < 2 * S_HT; i++) begin
            tick();
            if (s_irq) cnt_h++;
        end
        chk("irq_hold_cycles", 32'(cnt_h), 32'(2 * S_HT));
        vblank_ack = 1'b1;
        tick();
        vblank_ack = 1'b0;
        chk("irq_ack_clear", 32'(s_irq), 32'd0);
        tick();
        chk("irq_stays_clear", 32'(s_irq), 32'd0);

        // Ack held across the set point: set wins for exactly one cycle.
        do_reset();
        vblank_ack = 1'b1;
        wait_pos(0, S_VA);
        chk("irq_collision_set", 32'(s_irq), 32'd1);
        tick();
        chk("irq_collision_clear", 32'(s_irq), 32'd0);
        vblank_ack = 1'b0;
`endif

        // Randomized runs with random reset points (and random acks).
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(100, 3000);
            for (int i = 0; i < n; i++) begin
`ifdef VGA_TIMING_VBLANK_IRQ_EN
                vblank_ack = ($urandom_range(0, 99) < 4);
`endif
                tick();
            end
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
